// File: rtl/bus_mailbox_responder.sv
// Memory-mapped mailbox on the 6502 bus: an 8-byte register window with a
// 4-entry transmit FIFO, a scratch register, and read responses that are
// delayed by a programmable number of rdy-low wait states. The FIFO head is
// presented on a valid/ready stream toward a peripheral.
module bus_mailbox_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        access,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        rdy,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq_n
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [2:0] DEPTH     = 3'(FIFO_DEPTH);

  // Register offsets inside the window.
  localparam logic [2:0] OFF_DATA    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_SCRATCH = 3'd2;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  off_q, off_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  scratch_q, scratch_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  mem_q [4];

  logic        hit, idle, rd_hit, wr_hit;
  logic [2:0]  off;
  logic        full, empty, pop, push, accept, capture;
  logic [2:0]  rd_sel;
  logic [7:0]  status, rd_val;

  // Bus decode; accesses are only acted on while no read is in flight.
  assign hit    = access && (addr[15:3] == BASE_ADDR[15:3]);
  assign off    = addr[2:0];
  assign idle   = (state_q == S_IDLE);
  assign rd_hit = idle && hit && !we;
  assign wr_hit = idle && hit && we;

  assign full   = (count_q == DEPTH);
  assign empty  = (count_q == 3'd0);
  assign status = {full, empty, ovf_q, irq_en_q, 1'b0, count_q};

  // Zero-wait reads capture from the live offset; otherwise from the latched one.
  assign rd_sel = idle ? off : off_q;

  // Read mux over registered state only.
  always_comb begin
    case (rd_sel)
      OFF_DATA:    rd_val = 8'h00;
      OFF_STATUS:  rd_val = status;
      OFF_SCRATCH: rd_val = scratch_q;
      default:     rd_val = 8'hFF;
    endcase
  end

  // Read-response FSM: next state, wait counter and response capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_hit) begin
          off_d = off;
          cnt_d = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            capture = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    dout_d = capture ? rd_val : dout_q;
  end

  // FIFO bookkeeping and control/scratch register writes.
  always_comb begin
    pop       = !empty && out_ready;
    push      = wr_hit && (off == OFF_DATA);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    accept    = push && (!full || pop);
    wr_ptr_d  = wr_ptr_q + {1'b0, accept};
    rd_ptr_d  = rd_ptr_q + {1'b0, pop};
    count_d   = count_q + {2'b00, accept} - {2'b00, pop};
    scratch_d = scratch_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    if (wr_hit && (off == OFF_STATUS)) begin
      irq_en_d = din[4];
      if (din[5]) ovf_d = 1'b0;
    end
    if (wr_hit && (off == OFF_SCRATCH)) scratch_d = din;
    if (push && !accept) ovf_d = 1'b1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      off_q     <= 3'd0;
      dout_q    <= 8'h00;
      scratch_q <= 8'h00;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      dout_q    <= dout_d;
      scratch_q <= scratch_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an empty count masks stale entries and out_data is forced to zero.
    if (accept) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = dout_q;
  assign dout_en   = (state_q == S_RESP);
  assign rdy       = (state_q != S_WAIT);
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign irq_n     = !(irq_en_q && !empty);

endmodule

// File: doc/bus_mailbox_responder.md
# bus_mailbox_responder

Memory-mapped responder on the 6502 address/data bus. It decodes an 8-byte window, accepts CPU writes into a small transmit FIFO and control registers, and answers CPU reads with programmable wait states via `rdy`. A valid/ready stream on its far side drains the FIFO toward a peripheral. It sits beside `mem` on the CPU bus, and the top level muxes `D` using `dout_en`.

## Interface
Parameters:
- `BASE_ADDR`, default 16'hD000: window base; low 3 bits must be zero.
- `WAIT_CYCLES`, default 2: `rdy`-low cycles per read, range 0..15.
- `FIFO_DEPTH`, default 4: must be 4; the status count field is 3 bits.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `access`  in  1  bus cycle qualifier; `addr`/`we`/`din` sampled only when 1.
- `addr`  in  16  CPU address.
- `we`  in  1  1 = CPU write (inverse of `R_W_n`).
- `din`  in  8  CPU write data.
- `dout`  out  8  read response data.
- `dout_en`  out  1  drive `D` with `dout` this cycle.
- `rdy`  out  1  0 = stall CPU.
- `out_data`  out  8  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head.
- `irq_n`  out  1  active-low interrupt.

## Operation
- Decode: `hit` = `access` and `addr[15:3] == BASE_ADDR[15:3]`. `off` = `addr[2:0]`. Misses are ignored entirely.
- Register map, write effect / read value:
  - off 0 DATA: write pushes `din`; read returns 0x00.
  - off 1 STATUS: write bit4 sets `irq_en`; write bit5 = 1 clears `ovf`. Read = {full, empty, ovf, irq_en, 1'b0, count[2:0]}.
  - off 2 SCRATCH: R/W 8-bit.
  - off 3–7: writes ignored; read 0xFF.
- FSM states are IDLE, WAIT, RESP.
  - IDLE, read hit: latch `off`, load counter = WAIT_CYCLES. Go to WAIT, or to RESP if WAIT_CYCLES = 0.
  - IDLE, write hit: register or FIFO effect at that edge; stay in IDLE. Writes never stall.
  - WAIT: `rdy` = 0. The counter decrements each cycle; when it is 1, go to RESP.
  - RESP: `dout` = value, `dout_en` = 1, `rdy` = 1 for one cycle, then IDLE. The value is captured on the edge entering RESP, so STATUS reflects state at that edge.
  - Any hit while in WAIT or RESP is ignored.
- FIFO: 4 entries with circular read/write pointers that wrap 3→0, plus a count of 0..4.
  - Pop when `out_valid && out_ready`.
  - A push is accepted if count < 4, or if a pop occurs on the same edge.
  - A push to a full FIFO with no pop is dropped and sets sticky `ovf`.
  - A simultaneous push and pop leaves count unchanged.
- `out_data` = head entry when non-empty, else 0x00.
- `irq_n` = !(irq_en && !empty), derived from registered state only.
- Reset values: `rdy` = 1, `dout` = 0, `dout_en` = 0, `out_valid` = 0, `out_data` = 0, `irq_n` = 1. State IDLE; count, pointers, `ovf`, `irq_en` and SCRATCH all 0.
- Reset mid-read abandons the access. The next edge is IDLE with `rdy` = 1 and FIFO contents discarded.

## Timing
- A read hit sampled at edge N gives `rdy` = 0 for cycles N+1..N+WAIT_CYCLES and `dout_en` = 1 in cycle N+1+WAIT_CYCLES.
- A write hit at edge N makes the register visible from cycle N+1. A push into an empty FIFO raises `out_valid` in cycle N+1.
- Pop at edge N: the next head or deassertion appears in cycle N+1.
- No combinational path from any input to any output except `out_data` depending on pointer state. All outputs are registered or decoded from registered state.

## Test plan
- Reset: assert `reset` 3 cycles during WAIT → `rdy` = 1, `dout_en` = 0, `irq_n` = 1. A subsequent STATUS read returns 0x40.
- Fill and overflow:
  - With `out_ready` = 0, write 0x11, 0x22, 0x33, 0x44 to 0xD000 → STATUS 0x84.
  - Write 0x55 → dropped, STATUS 0xA4.
  - Drain → `out_data` sequence 11, 22, 33, 44, then `out_valid` = 0.
- Read latency: write 0x5A to 0xD002, then read at edge N with WAIT_CYCLES = 2 → `rdy` low in N+1 and N+2; `dout` = 0x5A with `dout_en` = 1 in N+3. With WAIT_CYCLES = 0 → response in N+1 and `rdy` never low.
- Full plus simultaneous pop: with the FIFO full and `out_ready` = 1, write 0x66 → count stays 4, `ovf` stays 0, and 0x66 is popped last.
- IRQ: write 0x10 to 0xD001 → `irq_n` = 1. Push 0x01 → `irq_n` = 0 next cycle. Pop → `irq_n` = 1. Write 0x30 after an overflow → `ovf` cleared.
- Decode boundaries: accesses at 0xCFFF and 0xD008 → no `rdy` drop, `dout_en` = 0, no state change. A read at 0xD007 returns 0xFF.
